// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
// Holds the control FSM states, the access-size codes and the fault rule.
package data_memory_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // Fault when the access is wider than a word or not naturally aligned.
  function automatic logic access_fault(input logic [1:0] size, input int addr, input int bytes);
    int nb;
    nb = 1 << size;
    return (nb > bytes) || ((addr & (nb - 1)) != 0);
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus of the data memory: one request channel, one response channel.
// The master issues loads/stores; the slave (the memory) answers each with one response.
interface data_memory_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_fault;
  logic                  init_done;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, init_done
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, init_done
  );
endinterface

// File: rtl/data_memory_extend.sv
// Load alignment: shifts the addressed byte lanes of a word down to bit 0
// and zero- or sign-extends them to the full word width.
module data_memory_extend
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [OFF_W-1:0]      offset,
  input  logic [1:0]            size,
  input  logic                  load_unsigned,
  output logic [DATA_WIDTH-1:0] data
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] shifted;
  logic                  sign;
  int                    nbytes;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    nbytes  = 1 << size;
    sign    = 1'b0;
    data    = shifted;
    for (int b = 0; b < BYTES; b++) begin
      if (b == nbytes - 1) sign = shifted[8*b+7];
    end
    // Full-width (or wider) accesses pass through untouched, so req_unsigned has no effect.
    if (nbytes < BYTES) begin
      for (int b = 0; b < BYTES; b++) begin
        if (b >= nbytes) data[8*b +: 8] = load_unsigned ? 8'h00 : {8{sign}};
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable word memory with a valid/ready request/response bus.
// After reset an INIT sweep clears one word per cycle before requests are accepted.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  data_memory_if.slave bus
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int WIDX_W = ADDR_WIDTH - OFF_W;
  localparam int DEPTH  = 2 ** WIDX_W;

  state_t                state_p0;
  state_t                state_nxt;
  logic [WIDX_W-1:0]     clr_cnt_p0;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready;
  logic                  accept;
  logic                  fault;
  logic                  we;
  logic [WIDX_W-1:0]     widx;
  logic [OFF_W-1:0]      off;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [DATA_WIDTH-1:0] rsp_rdata_p1;
  logic                  rsp_fault_p1;
  int                    nbytes;

  assign widx     = bus.req_addr[ADDR_WIDTH-1:OFF_W];
  assign off      = bus.req_addr[OFF_W-1:0];
  assign accept   = bus.req_valid && ready;
  assign fault    = access_fault(bus.req_size, int'(bus.req_addr), BYTES);
  assign we       = accept && bus.req_write && !fault;
  assign wdata_sh = bus.req_wdata << {off, 3'b000};
  assign rd_word  = mem[widx];

  always_comb begin
    nbytes = 1 << bus.req_size;
    be     = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (b >= int'(off) && b < int'(off) + nbytes) be[b] = 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state_p0;
    ready         = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.init_done = 1'b1;
    case (state_p0)
      INIT: begin
        bus.init_done = 1'b0;
        if (clr_cnt_p0 == '1) state_nxt = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.rsp_rdata = rsp_rdata_p1;
  assign bus.rsp_fault = rsp_fault_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0   <= INIT;
      clr_cnt_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (state_p0 == INIT) clr_cnt_p0 <= clr_cnt_p0 + 1'b1;
    end
  end

  // Array has no reset: the INIT sweep is the only clearing path.
  always_ff @(posedge clk) begin
    if (state_p0 == INIT) begin
      mem[clr_cnt_p0] <= '0;
    end else if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  data_memory_extend #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_W      (OFF_W)
  ) u_extend (
    .word          (rd_word),
    .offset        (off),
    .size          (bus.req_size),
    .load_unsigned (bus.req_unsigned),
    .data          (ext_data)
  );

  // Stage p1: response captured on the accept edge, held until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata_p1 <= '0;
      rsp_fault_p1 <= 1'b0;
    end else if (accept) begin
      rsp_fault_p1 <= fault;
      rsp_rdata_p1 <= (fault || bus.req_write) ? '0 : ext_data;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (8-bit address, 32-bit data, 64 words).
// Steps run in one initial block; each comparison is an immediate assertion.
module tb_data_memory;
  import data_memory_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  data_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request with immediate response consumption; returns the captured response.
  task automatic xfer(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic flt);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.rsp_ready    = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rsp_valid_after_accept", {31'b0, bus.rsp_valid}, 32'd1);
    rd = bus.rsp_rdata;
    flt = bus.rsp_fault;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_init();
    logic early;
    early = 1'b0;
    for (int i = 0; i < 63; i++) begin
      @(posedge clk);
      #1;
      if (bus.init_done || bus.req_ready) early = 1'b1;
    end
    check("init_not_early", {31'b0, early}, 32'd0);
    @(posedge clk);
    #1;
    check("init_done_at_64", {31'b0, bus.init_done}, 32'd1);
    check("req_ready_at_64", {31'b0, bus.req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        flt;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = SIZE_W;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 8'h00;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;

    #2;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_fault", {31'b0, bus.rsp_fault}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_init_done", {31'b0, bus.init_done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_init();

    xfer(1'b0, SIZE_W, 1'b0, 8'h00, 32'h0, rd, flt);
    check("init_ld_00", rd, 32'h0);
    check("init_ld_00_fault", {31'b0, flt}, 32'd0);
    xfer(1'b0, SIZE_W, 1'b0, 8'h04, 32'h0, rd, flt);
    check("init_ld_04", rd, 32'h0);
    xfer(1'b0, SIZE_W, 1'b0, 8'hFC, 32'h0, rd, flt);
    check("init_ld_fc", rd, 32'h0);
    check("init_ld_fc_fault", {31'b0, flt}, 32'd0);

    xfer(1'b1, SIZE_W, 1'b0, 8'h00, 32'hdeadbeef, rd, flt);
    check("st_w_00_rdata", rd, 32'h0);
    check("st_w_00_fault", {31'b0, flt}, 32'd0);
    xfer(1'b0, SIZE_W, 1'b0, 8'h00, 32'h0, rd, flt);
    check("ld_w_00", rd, 32'hdeadbeef);
    xfer(1'b0, SIZE_W, 1'b1, 8'h00, 32'h0, rd, flt);
    check("ld_w_00_unsigned", rd, 32'hdeadbeef);
    xfer(1'b0, SIZE_B, 1'b0, 8'h03, 32'h0, rd, flt);
    check("ld_bs_03", rd, 32'hffffffde);
    xfer(1'b0, SIZE_B, 1'b1, 8'h03, 32'h0, rd, flt);
    check("ld_bu_03", rd, 32'h000000de);
    xfer(1'b0, SIZE_H, 1'b0, 8'h02, 32'h0, rd, flt);
    check("ld_hs_02", rd, 32'hffffdead);
    xfer(1'b0, SIZE_H, 1'b1, 8'h00, 32'h0, rd, flt);
    check("ld_hu_00", rd, 32'h0000beef);

    xfer(1'b1, SIZE_W, 1'b0, 8'h04, 32'hcafebabe, rd, flt);
    xfer(1'b1, SIZE_B, 1'b0, 8'h05, 32'h000000AA, rd, flt);
    xfer(1'b0, SIZE_W, 1'b0, 8'h04, 32'h0, rd, flt);
    check("ld_w_04_merged", rd, 32'hcafeaabe);

    xfer(1'b1, SIZE_H, 1'b0, 8'h0A, 32'h00001234, rd, flt);
    xfer(1'b1, SIZE_B, 1'b0, 8'h08, 32'h00000080, rd, flt);
    xfer(1'b0, SIZE_W, 1'b0, 8'h08, 32'h0, rd, flt);
    check("ld_w_08", rd, 32'h12340080);
    xfer(1'b0, SIZE_B, 1'b0, 8'h08, 32'h0, rd, flt);
    check("ld_bs_08", rd, 32'hffffff80);
    xfer(1'b0, SIZE_H, 1'b0, 8'h0A, 32'h0, rd, flt);
    check("ld_hs_0a", rd, 32'h00001234);

    xfer(1'b1, SIZE_W, 1'b0, 8'h02, 32'h11111111, rd, flt);
    check("st_w_02_fault", {31'b0, flt}, 32'd1);
    check("st_w_02_rdata", rd, 32'h0);
    xfer(1'b0, SIZE_W, 1'b0, 8'h00, 32'h0, rd, flt);
    check("ld_w_00_after_fault", rd, 32'hdeadbeef);
    xfer(1'b0, SIZE_H, 1'b0, 8'h01, 32'h0, rd, flt);
    check("ld_h_01_fault", {31'b0, flt}, 32'd1);
    check("ld_h_01_rdata", rd, 32'h0);
    xfer(1'b0, SIZE_D, 1'b0, 8'h00, 32'h0, rd, flt);
    check("ld_d_00_fault", {31'b0, flt}, 32'd1);
    check("ld_d_00_rdata", rd, 32'h0);

    // Back-pressure: response must hold while rsp_ready stays low.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size = SIZE_W;
    bus.req_addr = 8'h00;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("hold_rsp_rdata", bus.rsp_rdata, 32'hdeadbeef);
      check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("midrst_init_done", {31'b0, bus.init_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_init();
    xfer(1'b0, SIZE_W, 1'b0, 8'h00, 32'h0, rd, flt);
    check("reinit_ld_00", rd, 32'h0);
    xfer(1'b0, SIZE_W, 1'b0, 8'h04, 32'h0, rd, flt);
    check("reinit_ld_04", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
